spi_slave_regs: RTL and testbench

// - SPI mode-0 responder (slave) at the far end of the team's SPI master link; decodes 24-bit frames
//   (command, address, data bytes, MSB first) and serves an internal register file.
// - CMD 8'hFF = write data byte to reg[addr]; CMD 8'h00 = read reg[addr] onto MISO during byte 3.
// - Any other command is ignored. Local port gives system logic read access and write notification.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_regs.sv | 139 +++++++++++++
 tb/tb_spi_slave_regs.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame constants and FSM state encoding, common to the responder and the master.
// Pure definitions: no latency, no flow control.
package spi_pkg;

  localparam logic [7:0] CMD_READ   = 8'h00;
  localparam logic [7:0] CMD_WRITE  = 8'hFF;
  localparam int         FRAME_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchroniser with rise/fall pulses derived from the synchronised copy.
// Latency: 2 clk to sync, pulses valid on the 3rd clk; no backpressure.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder serving a DEPTH x 8 register file over 24-bit cmd/addr/data frames.
// Latency: ~3 clk from each sclk edge (synchroniser); no backpressure, master paces everything.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;
  logic unused_sync;

  spi_state_t        state;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] regs [DEPTH];

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sclk),
    .sync     (sclk_s),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // cs_n resets high so release of reset never looks like a select.
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (cs_n),
    .sync     (cs_s),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  assign unused_sync = ^{sclk_s, cs_rise};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign rx_next   = {rx[DATA_W-2:0], mosi_s};
  assign miso      = tx[DATA_W-1];
  assign loc_rdata = regs[loc_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      rx       <= '0;
      tx       <= '0;
      cmd      <= '0;
      addr     <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (cs_s) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        rx      <= '0;
        tx      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
              rx      <= '0;
            end
          end
          CMD, ADDR, DATA: begin
            if (sclk_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  CMD: begin
                    cmd   <= rx_next;
                    state <= ADDR;
                  end
                  ADDR: begin
                    addr  <= rx_next[ADDR_W-1:0];
                    state <= DATA;
                    if (cmd == CMD_READ) tx <= regs[rx_next[ADDR_W-1:0]];
                  end
                  default: begin
                    state <= DONE;
                    tx    <= '0;
                    if (cmd == CMD_WRITE) begin
                      regs[addr] <= rx_next;
                      wr_valid   <= 1'b1;
                      wr_addr    <= addr;
                      wr_data    <= rx_next;
                    end
                  end
                endcase
              end
            end else if (sclk_fall && state == DATA && bit_cnt != 3'd0) begin
              // The fall closing bit 16 must not shift: tx[7] is the first data bit.
              tx <= {tx[DATA_W-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: SCLK = clk/10 mode-0 frames with hand-computed expectations.
// Inputs driven on negedge clk; miso sampled just before each sclk rising edge.
module tb_spi_slave_regs;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [3:0] loc_addr = 4'd0;
  logic [7:0] loc_rdata;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  int wr_base;
  logic [31:0] bits;

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_valid === 1'b1) wr_cycles++;

  spi_slave_regs #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .loc_addr  (loc_addr),
    .loc_rdata (loc_rdata),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    loc_addr = a;
    #1;
    check(tag, {24'h0, loc_rdata}, {24'h0, exp});
  endtask

  // frame is left-justified; captured miso bits land in the same positions.
  task automatic spi_xfer(input logic [31:0] frame, input int nbits, input bit keep_cs,
                          output logic [31:0] miso_bits);
    miso_bits = '0;
    cs_n = 1'b0;
    idle_clks(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[31-i];
      idle_clks(5);
      miso_bits[31-i] = miso;
      sclk = 1'b1;
      idle_clks(5);
      sclk = 1'b0;
    end
    idle_clks(6);
    if (!keep_cs) begin
      cs_n = 1'b1;
      mosi = 1'b0;
      idle_clks(8);
    end
  endtask

  initial begin
    // Reset state
    idle_clks(4);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
    check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
    check("rst_wr_data", {24'h0, wr_data}, 32'h0);
    chk_reg("rst_reg0", 4'd0, 8'h00);
    chk_reg("rst_reg2", 4'd2, 8'h00);
    rst = 1'b1;
    idle_clks(4);

    // Write FF,12,ED: address 0x12 mod 16 = 2
    wr_base = wr_cycles;
    spi_xfer(32'hFF12ED00, 24, 1'b0, bits);
    check("wr1_pulses", wr_cycles - wr_base, 32'd1);
    check("wr1_addr", {28'h0, wr_addr}, 32'h2);
    check("wr1_data", {24'h0, wr_data}, 32'hED);
    check("wr1_miso", bits, 32'h0);
    chk_reg("wr1_reg2", 4'd2, 8'hED);

    // Read 00,12,xx: ED in byte 3 only
    wr_base = wr_cycles;
    spi_xfer(32'h0012_0000, 24, 1'b0, bits);
    check("rd1_miso", bits, 32'h0000ED00);
    check("rd1_pulses", wr_cycles - wr_base, 32'd0);
    check("rd1_miso_idle", {31'h0, miso}, 32'h0);

    // Unknown command A5,34,CB
    wr_base = wr_cycles;
    spi_xfer(32'hA534CB00, 24, 1'b0, bits);
    check("unk_pulses", wr_cycles - wr_base, 32'd0);
    check("unk_miso", bits, 32'h0);
    chk_reg("unk_reg4", 4'd4, 8'h00);

    // Write aborted after 12 bits, then complete write
    wr_base = wr_cycles;
    spi_xfer(32'hFF34CB00, 12, 1'b0, bits);
    check("abort_state", {29'h0, dut.state}, {29'h0, IDLE});
    check("abort_pulses", wr_cycles - wr_base, 32'd0);
    chk_reg("abort_reg4", 4'd4, 8'h00);
    check("abort_wr_addr", {28'h0, wr_addr}, 32'h2);
    wr_base = wr_cycles;
    spi_xfer(32'hFF34CB00, 24, 1'b0, bits);
    check("wr2_pulses", wr_cycles - wr_base, 32'd1);
    chk_reg("wr2_reg4", 4'd4, 8'hCB);
    check("wr2_addr", {28'h0, wr_addr}, 32'h4);
    chk_reg("wr2_reg2_kept", 4'd2, 8'hED);

    // 32-bit frame FF,07,98,55: trailing byte ignored
    wr_base = wr_cycles;
    spi_xfer(32'hFF079855, 32, 1'b0, bits);
    check("long_pulses", wr_cycles - wr_base, 32'd1);
    check("long_data", {24'h0, wr_data}, 32'h98);
    check("long_miso", bits, 32'h0);
    chk_reg("long_reg7", 4'd7, 8'h98);
    spi_xfer(32'h0007_0000, 24, 1'b0, bits);
    check("rd2_miso", bits, 32'h00009800);

    // Reset asserted mid-frame of write FF,07,11
    wr_base = wr_cycles;
    spi_xfer(32'hFF071100, 20, 1'b1, bits);
    rst = 1'b0;
    idle_clks(4);
    check("mrst_miso", {31'h0, miso}, 32'h0);
    check("mrst_wr_addr", {28'h0, wr_addr}, 32'h0);
    check("mrst_wr_data", {24'h0, wr_data}, 32'h0);
    chk_reg("mrst_reg7", 4'd7, 8'h00);
    chk_reg("mrst_reg2", 4'd2, 8'h00);
    chk_reg("mrst_reg4", 4'd4, 8'h00);
    rst = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b0;
    idle_clks(8);
    check("mrst_state", {29'h0, dut.state}, {29'h0, IDLE});
    spi_xfer(32'h0007_0000, 24, 1'b0, bits);
    check("mrst_rd_miso", bits, 32'h0);
    check("mrst_pulses", wr_cycles - wr_base, 32'd0);
    chk_reg("mrst_reg7_after", 4'd7, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
